// File: rtl/sb_rx_deser.sv
// Sideband RX deserializer: LSB-first serial bits into DATA_W-bit words,
// with inter-packet idle-gap enforcement and truncated-packet detection.
module sb_rx_deser #(
  parameter int DATA_W  = 64,
  parameter int GAP_MIN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_ser_data,
  input  logic              i_ser_valid,
  output logic [DATA_W-1:0] o_deser_data,
  output logic              o_de_ser_done,
  output logic              o_frame_error,
  output logic              o_gap_error,
  output logic              o_busy
);

  localparam int CW = $clog2(DATA_W);
  localparam int GW = (GAP_MIN > 0) ? $clog2(GAP_MIN + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [GW-1:0] GMAX = GW'(GAP_MIN);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     bit_cnt, bit_nxt;
  logic [GW-1:0]     gap_cnt, gap_nxt;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [DATA_W-1:0] shifted;
  logic              done_nxt;
  logic              ferr_nxt;
  logic              gerr_nxt;

  assign shifted = {i_ser_data, shift_reg[DATA_W-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      shift_reg     <= '0;
      o_deser_data  <= '0;
      o_de_ser_done <= 1'b0;
      o_frame_error <= 1'b0;
      o_gap_error   <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_nxt;
      gap_cnt       <= gap_nxt;
      shift_reg     <= shift_nxt;
      o_deser_data  <= data_nxt;
      o_de_ser_done <= done_nxt;
      o_frame_error <= ferr_nxt;
      o_gap_error   <= gerr_nxt;
      o_busy        <= (state_nxt == SHIFT);
    end
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    gap_nxt   = gap_cnt;
    shift_nxt = shift_reg;
    data_nxt  = o_deser_data;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    gerr_nxt  = 1'b0;
    if (!i_enable) begin
      state_nxt = IDLE;
      bit_nxt   = '0;
      gap_nxt   = '0;
      shift_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_ser_valid) begin
            shift_nxt = shifted;
            bit_nxt   = CW'(1);
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (!i_ser_valid) begin
            ferr_nxt  = 1'b1;
            bit_nxt   = '0;
            shift_nxt = '0;
            state_nxt = IDLE;
          end else if (bit_cnt == LAST) begin
            data_nxt  = shifted;
            done_nxt  = 1'b1;
            bit_nxt   = '0;
            gap_nxt   = '0;
            shift_nxt = '0;
            state_nxt = (GAP_MIN == 0) ? IDLE : GAP;
          end else begin
            shift_nxt = shifted;
            bit_nxt   = bit_cnt + CW'(1);
          end
        end
        GAP: begin
          if (i_ser_valid) begin
            // Early start is flagged but the bit is kept as bit 0.
            gerr_nxt  = (gap_cnt < GMAX);
            shift_nxt = shifted;
            bit_nxt   = CW'(1);
            gap_nxt   = '0;
            state_nxt = SHIFT;
          end else begin
            gap_nxt = gap_cnt + GW'(1);
            if (gap_nxt == GMAX) begin
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          bit_nxt   = '0;
          gap_nxt   = '0;
          shift_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_rx_deser.sv
// Scoreboard bench for sb_rx_deser: directed packets, expected pulses
// queued by the driver and matched by a negedge monitor.
module tb_sb_rx_deser;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b1;
  logic        i_ser_data = 1'b0;
  logic        i_ser_valid = 1'b0;
  logic [63:0] o_deser_data;
  logic        o_de_ser_done;
  logic        o_frame_error;
  logic        o_gap_error;
  logic        o_busy;

  typedef struct {
    int          kind;
    logic [63:0] data;
  } ev_t;

  ev_t q[$];
  int  passed = 0;
  int  total = 0;
  int  busy_cnt = 0;
  bit  count_busy = 1'b0;

  sb_rx_deser #(.DATA_W(64), .GAP_MIN(32)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_ser_data   (i_ser_data),
    .i_ser_valid  (i_ser_valid),
    .o_deser_data (o_deser_data),
    .o_de_ser_done(o_de_ser_done),
    .o_frame_error(o_frame_error),
    .o_gap_error  (o_gap_error),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_ev(input int k);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d expected none", k);
    end else begin
      e = q.pop_front();
      if (e.kind != k)
        $display("FAIL event_kind: got %0d expected %0d", k, e.kind);
      else if (k == 0 && o_deser_data !== e.data)
        $display("FAIL done_data: got %h expected %h", o_deser_data, e.data);
      else
        passed++;
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_de_ser_done) check_ev(0);
      if (o_frame_error) check_ev(1);
      if (o_gap_error) check_ev(2);
    end
    if (count_busy && o_busy) busy_cnt++;
  end

  task automatic cyc(input logic v, input logic d);
    @(posedge i_clk);
    #1;
    i_ser_valid = v;
    i_ser_data  = d;
  endtask

  task automatic send(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, w[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic exp_done(input logic [63:0] w);
    q.push_back('{kind: 0, data: w});
  endtask

  task automatic exp_kind(input int k);
    q.push_back('{kind: k, data: 64'h0});
  endtask

  localparam logic [63:0] W1 = 64'hA5A5_5A5A_DEAD_BEEF;
  localparam logic [63:0] WL = 64'h0000_0000_0000_0001;
  localparam logic [63:0] WH = 64'h8000_0000_0000_0000;
  localparam logic [63:0] W4 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W5 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] W6 = 64'h5555_AAAA_3333_CCCC;

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_data", o_deser_data, 64'h0);
    chk("rst_done", {63'h0, o_de_ser_done}, 64'h0);
    chk("rst_ferr", {63'h0, o_frame_error}, 64'h0);
    chk("rst_gerr", {63'h0, o_gap_error}, 64'h0);
    chk("rst_busy", {63'h0, o_busy}, 64'h0);
    i_rst = 1'b0;
    idle(2);

    count_busy = 1'b1;
    exp_done(W1);
    send(W1, 64);
    idle(5);
    count_busy = 1'b0;
    chk("busy_cycles", 64'(busy_cnt), 64'd63);
    chk("word1_held", o_deser_data, W1);
    idle(40);

    exp_done(WL);
    exp_done(WH);
    send(WL, 64);
    idle(32);
    send(WH, 64);
    idle(40);

    exp_done(WL);
    exp_kind(2);
    exp_done(WH);
    send(WL, 64);
    idle(10);
    send(WH, 64);
    idle(40);

    exp_done(W4);
    exp_kind(2);
    exp_done(W5);
    send(W4, 64);
    idle(31);
    send(W5, 64);
    idle(40);

    exp_kind(1);
    send(W6, 20);
    idle(5);
    chk("frame_hold", o_deser_data, W5);
    exp_done(W6);
    send(W6, 64);
    idle(40);

    send(W1, 40);
    @(posedge i_clk);
    #1;
    i_enable    = 1'b0;
    i_ser_valid = 1'b1;
    i_ser_data  = W1[40];
    idle(3);
    chk("en_busy", {63'h0, o_busy}, 64'h0);
    i_enable = 1'b1;
    idle(2);
    chk("en_hold", o_deser_data, W6);
    exp_done(W4);
    send(W4, 64);
    idle(40);

    send(W5, 63);
    @(posedge i_clk);
    #1;
    i_rst       = 1'b1;
    i_ser_valid = 1'b1;
    i_ser_data  = W5[63];
    @(posedge i_clk);
    #1;
    i_rst       = 1'b0;
    i_ser_valid = 1'b0;
    idle(3);
    chk("rst63_data", o_deser_data, 64'h0);
    exp_done(WH);
    send(WH, 64);
    idle(10);

    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL missing_events: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
